// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS-485 transmit path.
// Holds the frame FSM states and the baud codes handed to the bit-rate generator.
package rs485_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    START,
    DATA,
    PARITY,
    STOP,
    LAG
  } tx_state_e;

  localparam logic [3:0] BAUD_9600    = 4'd1;
  localparam logic [3:0] BAUD_19200   = 4'd2;
  localparam logic [3:0] BAUD_38400   = 4'd3;
  localparam logic [3:0] BAUD_57600   = 4'd4;
  localparam logic [3:0] BAUD_115200  = 4'd5;
  localparam logic [3:0] BAUD_DEFAULT = BAUD_115200;

endpackage

// File: rtl/rs485_tx_ctrl.sv
// RS-485 frame transmitter with driver-enable guard periods.
// Bit timing comes from an external generator via bps_en ticks.
module rs485_tx_ctrl
  import rs485_pkg::*;
#(
  parameter int GUARD_BITS = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [3:0] baud_sel,
  output logic [3:0] bps_sel,
  output logic       bps_cnt_clr,
  input  logic       bps_en,
  output logic       txd,
  output logic       de,
  output logic       re_n,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam bit HAS_GUARD = GUARD_BITS != 0;
  localparam bit HAS_PAR   = PARITY_EN != 0;
  localparam bit ODD       = PARITY_ODD != 0;
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_BITS - 1);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS - 1);

  tx_state_e            state;
  logic [3:0]           cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 tick;
  logic                 stop_end;

  // The generator phase restarts on bps_cnt_clr, so a tick then is stale.
  assign tick     = bps_en & ~bps_cnt_clr;
  assign stop_end = (state == STOP) & tick;
  assign tx_ready = (state == IDLE) | stop_end;
  assign tx_done  = stop_end;
  assign tx_busy  = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      shreg       <= '0;
      par         <= 1'b0;
      txd         <= 1'b1;
      de          <= 1'b0;
      re_n        <= 1'b0;
      bps_cnt_clr <= 1'b0;
      bps_sel     <= BAUD_DEFAULT;
    end else begin
      bps_cnt_clr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg       <= tx_data;
            par         <= 1'b0;
            bps_sel     <= baud_sel;
            bps_cnt_clr <= 1'b1;
            de          <= 1'b1;
            re_n        <= 1'b1;
            if (HAS_GUARD) begin
              state <= LEAD;
              cnt   <= GUARD_LAST;
              txd   <= 1'b1;
            end else begin
              state <= START;
              cnt   <= 4'd0;
              txd   <= 1'b0;
            end
          end
        end
        LEAD: begin
          if (tick) begin
            if (cnt == 4'd0) begin
              state <= START;
              cnt   <= 4'd0;
              txd   <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            cnt   <= DATA_LAST;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            par   <= par ^ shreg[0];
            shreg <= shreg >> 1;
            if (cnt == 4'd0) begin
              cnt <= 4'd0;
              if (HAS_PAR) begin
                state <= PARITY;
                txd   <= par ^ shreg[0] ^ ODD;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              cnt <= cnt - 4'd1;
              txd <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            cnt   <= 4'd0;
            txd   <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (tx_valid) begin
              // Back-to-back byte: line stays driven, generator phase kept.
              shreg <= tx_data;
              par   <= 1'b0;
              state <= START;
              cnt   <= 4'd0;
              txd   <= 1'b0;
            end else if (HAS_GUARD) begin
              state <= LAG;
              cnt   <= GUARD_LAST;
              txd   <= 1'b1;
            end else begin
              state <= IDLE;
              cnt   <= 4'd0;
              txd   <= 1'b1;
              de    <= 1'b0;
              re_n  <= 1'b0;
            end
          end
        end
        LAG: begin
          if (tick) begin
            if (cnt == 4'd0) begin
              state <= IDLE;
              txd   <= 1'b1;
              de    <= 1'b0;
              re_n  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs485_tx_ctrl.sv
// Randomized bench for rs485_tx_ctrl against a bit-list frame model.
// Three instances cover guard lengths 1/2/0 and none/even/odd parity.
module tb_rs485_tx_ctrl;
  import rs485_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[3];
  logic [7:0] tx_data[3];
  logic       tx_valid[3];
  logic       bps_en[3];
  logic [3:0] baud_sel[3];
  logic       tx_ready[3];
  logic [3:0] bps_sel[3];
  logic       bps_cnt_clr[3];
  logic       txd[3];
  logic       de[3];
  logic       re_n[3];
  logic       tx_busy[3];
  logic       tx_done[3];

  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_bps[3];
  logic [7:0] q[$];

  rs485_tx_ctrl #(.GUARD_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .baud_sel(baud_sel[0]), .bps_sel(bps_sel[0]),
    .bps_cnt_clr(bps_cnt_clr[0]), .bps_en(bps_en[0]),
    .txd(txd[0]), .de(de[0]), .re_n(re_n[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  rs485_tx_ctrl #(.GUARD_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .baud_sel(baud_sel[1]), .bps_sel(bps_sel[1]),
    .bps_cnt_clr(bps_cnt_clr[1]), .bps_en(bps_en[1]),
    .txd(txd[1]), .de(de[1]), .re_n(re_n[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  rs485_tx_ctrl #(.GUARD_BITS(0), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .tx_data(tx_data[2]),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .baud_sel(baud_sel[2]), .bps_sel(bps_sel[2]),
    .bps_cnt_clr(bps_cnt_clr[2]), .bps_en(bps_en[2]),
    .txd(txd[2]), .de(de[2]), .re_n(re_n[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
  );

  function automatic int gb(int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 0;
  endfunction

  function automatic int pe(int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic logic po(int k);
    return k == 2;
  endfunction

  // Line level during bit period i of a frame: lead, start, data, parity, stop, lag.
  function automatic logic fbit(int k, logic [7:0] b, int i);
    int g;
    g = gb(k);
    if (i < g) return 1'b1;
    if (i == g) return 1'b0;
    if (i < g + 9) return b[3'(i - g - 1)];
    if (pe(k) == 1 && i == g + 9) return (^b) ^ po(k);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input int k, input bit hold, input int period,
                     input bit clr_tick, input bit rst_bit3);
    bit         idle = 1'b1;
    bit         pclr = 1'b0;
    bit         did_rst = 1'b0;
    bit         vtick, at_stop, exp_ready, accept;
    logic [7:0] cur = 8'h00;
    int         pos = 0;
    int         cyc = 0;
    int         g, stop_idx, last;
    logic       lvl;
    g = gb(k);
    stop_idx = g + 9 + pe(k);
    last = stop_idx + g;
    while ((q.size() > 0 || !idle) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      rst_n[k]    = 1'b1;
      tx_valid[k] = (q.size() > 0) && (hold || idle);
      tx_data[k]  = (q.size() > 0) ? q[0] : 8'($urandom);
      baud_sel[k] = 4'($urandom_range(1, 5));
      bps_en[k]   = ((cyc % period) == 0) || (clr_tick && pclr);
      if (rst_bit3 && !did_rst && !idle && pos == g + 4) begin
        rst_n[k] = 1'b0;
        did_rst  = 1'b1;
      end
      #1;
      if (!rst_n[k]) begin
        check($sformatf("u%0d_rst_line", k),
              {5'b0, txd[k], de[k], re_n[k]}, 8'b100);
        check($sformatf("u%0d_rst_hs", k),
              {4'b0, tx_ready[k], tx_done[k], tx_busy[k], bps_cnt_clr[k]},
              8'b1000);
        check($sformatf("u%0d_rst_bps", k), {4'b0, bps_sel[k]},
              {4'b0, BAUD_DEFAULT});
        idle = 1'b1;
        pclr = 1'b0;
        exp_bps[k] = BAUD_DEFAULT;
        continue;
      end
      vtick     = bps_en[k] && !pclr;
      at_stop   = !idle && vtick && pos == stop_idx;
      exp_ready = idle || at_stop;
      lvl       = idle ? 1'b1 : fbit(k, cur, pos);
      check($sformatf("u%0d_line", k),
            {5'b0, txd[k], de[k], re_n[k]},
            {5'b0, lvl, !idle, !idle});
      check($sformatf("u%0d_hs", k),
            {4'b0, tx_ready[k], tx_done[k], tx_busy[k], bps_cnt_clr[k]},
            {4'b0, exp_ready, at_stop, !idle, pclr});
      check($sformatf("u%0d_bps", k), {4'b0, bps_sel[k]}, {4'b0, exp_bps[k]});
      accept = tx_valid[k] && exp_ready;
      pclr = 1'b0;
      if (idle) begin
        if (accept) begin
          cur = q.pop_front();
          exp_bps[k] = baud_sel[k];
          pos  = 0;
          pclr = 1'b1;
          idle = 1'b0;
        end
      end else if (vtick) begin
        if (at_stop && accept) begin
          cur = q.pop_front();
          pos = g;
        end else begin
          pos++;
          if (pos > last) idle = 1'b1;
        end
      end
    end
    check($sformatf("u%0d_timeout", k), {7'b0, cyc < 3000}, 8'd1);
    @(negedge clk);
    tx_valid[k] = 1'b0;
    bps_en[k]   = 1'b0;
    rst_n[k]    = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k]    = 1'b0;
      tx_data[k]  = 8'h00;
      tx_valid[k] = 1'b0;
      bps_en[k]   = 1'b0;
      baud_sel[k] = 4'd5;
      exp_bps[k]  = BAUD_DEFAULT;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_init_line", k),
            {5'b0, txd[k], de[k], re_n[k]}, 8'b100);
      check($sformatf("u%0d_init_hs", k),
            {4'b0, tx_ready[k], tx_done[k], tx_busy[k], bps_cnt_clr[k]},
            8'b1000);
      check($sformatf("u%0d_init_bps", k), {4'b0, bps_sel[k]},
            {4'b0, BAUD_DEFAULT});
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    q = '{8'hA5};
    run(0, 1'b0, 4, 1'b0, 1'b0);
    q = '{8'h55, 8'hAA};
    run(0, 1'b1, 3, 1'b0, 1'b0);
    q = '{8'h3C, 8'hC3};
    run(0, 1'b1, 4, 1'b0, 1'b1);
    q = '{8'h07};
    run(0, 1'b0, 2, 1'b1, 1'b0);
    q = '{8'h07};
    run(1, 1'b0, 2, 1'b0, 1'b0);
    q = '{8'h07};
    run(2, 1'b0, 3, 1'b1, 1'b0);

    for (int r = 0; r < 15; r++) begin
      int k;
      int n;
      k = r % 3;
      n = $urandom_range(1, 3);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run(k, 1'($urandom), $urandom_range(1, 5), 1'($urandom),
          ($urandom % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
